// File: rtl/mips_pkg.sv
// Shared constants for the five-stage MIPS pipeline (register file, MEM/WB, forwarding).
package mips_pkg;
  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 5;
  localparam int REG_COUNT = 32;
  localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/wb_regfile_if.sv
// MEM/WB write-back fields and ID-stage read ports of the register file.
interface wb_regfile_if #(parameter int CNT_W = 32);
  import mips_pkg::*;

  logic [ADDR_W-1:0] WB_Rd;
  logic [DATA_W-1:0] WB_ALUOut;
  logic [DATA_W-1:0] WB_Read_Data;
  logic              WB_MemtoReg;
  logic              WB_RegWrite;
  logic [ADDR_W-1:0] ID_Rs;
  logic [ADDR_W-1:0] ID_Rt;
  logic [DATA_W-1:0] ID_RsData;
  logic [DATA_W-1:0] ID_RtData;
  logic [DATA_W-1:0] WB_WriteData;
  logic              WB_WriteEn;
  logic [CNT_W-1:0]  Commit_Count;

  modport master (
    output WB_Rd, WB_ALUOut, WB_Read_Data, WB_MemtoReg, WB_RegWrite, ID_Rs, ID_Rt,
    input  ID_RsData, ID_RtData, WB_WriteData, WB_WriteEn, Commit_Count
  );

  modport slave (
    input  WB_Rd, WB_ALUOut, WB_Read_Data, WB_MemtoReg, WB_RegWrite, ID_Rs, ID_Rt,
    output ID_RsData, ID_RtData, WB_WriteData, WB_WriteEn, Commit_Count
  );
endinterface

// File: rtl/wb_select.sv
// Write-back value mux and write-enable qualification (writes to r0 are dropped).
module wb_select
  import mips_pkg::*;
(
  input  logic [ADDR_W-1:0] rd,
  input  logic              reg_write,
  input  logic              memto_reg,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [DATA_W-1:0] read_data,
  output logic [DATA_W-1:0] write_data,
  output logic              write_en
);
  assign write_data = memto_reg ? read_data : alu_out;
  assign write_en   = reg_write && (rd != REG_ZERO);
endmodule

// File: rtl/wb_regfile.sv
// Write-back stage and 32x32 register file with two bypassed combinational read ports
// and a committed-write counter.
module wb_regfile
  import mips_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input logic         clk,
  input logic         reset,
  wb_regfile_if.slave bus
);
  logic [DATA_W-1:0] regs [REG_COUNT];
  logic [DATA_W-1:0] write_data;
  logic              write_en;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic [CNT_W-1:0]  commit_count;

  wb_select u_wb_select (
    .rd         (bus.WB_Rd),
    .reg_write  (bus.WB_RegWrite),
    .memto_reg  (bus.WB_MemtoReg),
    .alu_out    (bus.WB_ALUOut),
    .read_data  (bus.WB_Read_Data),
    .write_data (write_data),
    .write_en   (write_en)
  );

  // NOTE: the array is cleared by reset, so it must stay flops rather than a RAM macro;
  // sequential state uses <= so every reader sees the pre-edge value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
      commit_count <= '0;
    end else if (write_en) begin
      regs[bus.WB_Rd] <= write_data;
      commit_count    <= commit_count + CNT_W'(1);
    end
  end

  // NOTE: default first so no path leaves the output unassigned (no latch).
  always_comb begin
    rs_data = '0;
    if (bus.ID_Rs != REG_ZERO)
      rs_data = (write_en && bus.ID_Rs == bus.WB_Rd) ? write_data : regs[bus.ID_Rs];
  end

  always_comb begin
    rt_data = '0;
    if (bus.ID_Rt != REG_ZERO)
      rt_data = (write_en && bus.ID_Rt == bus.WB_Rd) ? write_data : regs[bus.ID_Rt];
  end

  assign bus.ID_RsData    = rs_data;
  assign bus.ID_RtData    = rt_data;
  assign bus.WB_WriteData = write_data;
  assign bus.WB_WriteEn   = write_en;
  assign bus.Commit_Count = commit_count;
endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: vector table plus reset and counter-wrap sequences.
module tb_wb_regfile;
  import mips_pkg::*;

  logic clk;
  logic reset;

  wb_regfile_if #(.CNT_W(32)) bus ();
  wb_regfile_if #(.CNT_W(4))  bus4 ();

  wb_regfile #(.CNT_W(32)) dut (.clk(clk), .reset(reset), .bus(bus));
  wb_regfile #(.CNT_W(4))  dut4 (.clk(clk), .reset(reset), .bus(bus4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic        m2r;
    logic        we;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [31:0] exp_wdata;
    logic        exp_we;
    logic [31:0] exp_rs;
    logic [31:0] exp_rt;
    logic [31:0] exp_cnt;
  } vec_t;

  vec_t vecs [11];

  task automatic drive(input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] rdata,
                       input logic m2r, input logic we, input logic [4:0] rs, input logic [4:0] rt);
    bus.WB_Rd = rd; bus.WB_ALUOut = alu; bus.WB_Read_Data = rdata;
    bus.WB_MemtoReg = m2r; bus.WB_RegWrite = we; bus.ID_Rs = rs; bus.ID_Rt = rt;
  endtask

  initial begin
    reset = 1'b1;
    drive(5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 5'd0);
    bus4.WB_Rd = 5'd1; bus4.WB_ALUOut = 32'h0; bus4.WB_Read_Data = 32'h0;
    bus4.WB_MemtoReg = 1'b0; bus4.WB_RegWrite = 1'b0; bus4.ID_Rs = 5'd0; bus4.ID_Rt = 5'd0;

    //           rd     alu           rdata         m  w  rs     rt     wdata         we  rs_exp        rt_exp        cnt
    vecs[0]  = '{5'd3,  32'h12345678, 32'h00000000, 0, 1, 5'd3,  5'd0,  32'h12345678, 1, 32'h12345678, 32'h00000000, 32'd1};
    vecs[1]  = '{5'd0,  32'h00000000, 32'h00000000, 0, 0, 5'd3,  5'd7,  32'h00000000, 0, 32'h12345678, 32'h00000000, 32'd1};
    vecs[2]  = '{5'd7,  32'h00000001, 32'hCAFEF00D, 1, 1, 5'd3,  5'd7,  32'hCAFEF00D, 1, 32'h12345678, 32'hCAFEF00D, 32'd2};
    vecs[3]  = '{5'd0,  32'hFFFFFFFF, 32'h00000000, 0, 1, 5'd0,  5'd0,  32'hFFFFFFFF, 0, 32'h00000000, 32'h00000000, 32'd2};
    vecs[4]  = '{5'd9,  32'hAAAA5555, 32'h00000000, 0, 0, 5'd7,  5'd9,  32'hAAAA5555, 0, 32'hCAFEF00D, 32'h00000000, 32'd2};
    vecs[5]  = '{5'd9,  32'h11111111, 32'h00000000, 0, 1, 5'd9,  5'd3,  32'h11111111, 1, 32'h11111111, 32'h12345678, 32'd3};
    vecs[6]  = '{5'd9,  32'hAAAA5555, 32'h00000000, 0, 0, 5'd7,  5'd9,  32'hAAAA5555, 0, 32'hCAFEF00D, 32'h11111111, 32'd3};
    vecs[7]  = '{5'd12, 32'h0BADC0DE, 32'h00000000, 0, 1, 5'd12, 5'd12, 32'h0BADC0DE, 1, 32'h0BADC0DE, 32'h0BADC0DE, 32'd4};
    vecs[8]  = '{5'd12, 32'h00000000, 32'h00000055, 1, 0, 5'd12, 5'd7,  32'h00000055, 0, 32'h0BADC0DE, 32'hCAFEF00D, 32'd4};
    vecs[9]  = '{5'd31, 32'h80000001, 32'h00000000, 0, 1, 5'd31, 5'd1,  32'h80000001, 1, 32'h80000001, 32'h00000000, 32'd5};
    vecs[10] = '{5'd0,  32'h00000000, 32'h00000000, 0, 0, 5'd31, 5'd12, 32'h00000000, 0, 32'h80000001, 32'h0BADC0DE, 32'd5};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    bus.ID_Rs = 5'd5; bus.ID_Rt = 5'd31;
    #1;
    check("reset_rs", bus.ID_RsData, 32'h0);
    check("reset_rt", bus.ID_RtData, 32'h0);
    check("reset_cnt", bus.Commit_Count, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      drive(vecs[i].rd, vecs[i].alu, vecs[i].rdata, vecs[i].m2r, vecs[i].we, vecs[i].rs, vecs[i].rt);
      #1;
      check($sformatf("v%0d_wdata", i), bus.WB_WriteData, vecs[i].exp_wdata);
      check($sformatf("v%0d_we", i), {31'b0, bus.WB_WriteEn}, {31'b0, vecs[i].exp_we});
      check($sformatf("v%0d_rs", i), bus.ID_RsData, vecs[i].exp_rs);
      check($sformatf("v%0d_rt", i), bus.ID_RtData, vecs[i].exp_rt);
      @(posedge clk);
      #1;
      check($sformatf("v%0d_cnt", i), bus.Commit_Count, vecs[i].exp_cnt);
    end

    // Mid-run async reset after regs[5] = DEADBEEF
    @(negedge clk);
    drive(5'd5, 32'hDEADBEEF, 32'h0, 1'b0, 1'b1, 5'd0, 5'd0);
    @(negedge clk);
    drive(5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd5, 5'd3);
    #1;
    check("pre_rst_r5", bus.ID_RsData, 32'hDEADBEEF);
    check("pre_rst_cnt", bus.Commit_Count, 32'd6);
    #1;
    reset = 1'b1;
    #1;
    check("async_rst_r5", bus.ID_RsData, 32'h0);
    check("async_rst_r3", bus.ID_RtData, 32'h0);
    check("async_rst_cnt", bus.Commit_Count, 32'h0);

    // Writes are ignored while reset is held; bypass still visible combinationally
    @(negedge clk);
    drive(5'd5, 32'h00000077, 32'h0, 1'b0, 1'b1, 5'd5, 5'd0);
    #1;
    check("rst_bypass_r5", bus.ID_RsData, 32'h00000077);
    @(posedge clk);
    #1;
    bus.WB_RegWrite = 1'b0;
    #1;
    check("rst_nowrite_r5", bus.ID_RsData, 32'h0);
    check("rst_nowrite_cnt", bus.Commit_Count, 32'h0);

    // First write after release lands on the next rising edge
    @(negedge clk);
    reset = 1'b0;
    bus.WB_RegWrite = 1'b1;
    @(posedge clk);
    #1;
    bus.WB_RegWrite = 1'b0;
    #1;
    check("post_rst_r5", bus.ID_RsData, 32'h00000077);
    check("post_rst_cnt", bus.Commit_Count, 32'd1);

    // Counter wrap on the 4-bit build: 15 writes reach 0xF, the 16th wraps to 0
    @(negedge clk);
    bus4.WB_RegWrite = 1'b1;
    for (int i = 0; i < 15; i++) begin
      bus4.WB_ALUOut = 32'(i);
      @(negedge clk);
    end
    bus4.WB_RegWrite = 1'b0;
    #1;
    check("cnt4_max", {28'b0, bus4.Commit_Count}, 32'hF);
    bus4.WB_RegWrite = 1'b1;
    @(posedge clk);
    #1;
    bus4.WB_RegWrite = 1'b0;
    check("cnt4_wrap", {28'b0, bus4.Commit_Count}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
